iobus_write_buffer: RTL and testbench

IOBUS_WRITE_BUFFER -- requirements
Module: iobus_write_buffer

---
 rtl/otter_iobus_pkg.sv | 22 ++
 rtl/iobus_write_buffer_if.sv | 25 ++
 rtl/iobus_fifo.sv | 82 ++++++++
 rtl/iobus_write_buffer.sv | 100 ++++++++++
 tb/tb_iobus_write_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/otter_iobus_pkg.sv
// Shared types and constants for the MCU store write buffer.
// Holds the buffered entry layout, the drain FSM states and the MMIO window check.
package otter_iobus_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1100_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } iobus_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    // Unsigned compare: stores at or above the base address are buffered.
    function automatic logic in_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/iobus_write_buffer_if.sv
// Bus bundle between the MCU store port, the write buffer and the peripheral bus.
interface iobus_write_buffer_if;

    logic        IOBUS_WR;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        BUF_FULL;
    logic        BUF_EMPTY;
    logic        PERIPH_VALID;
    logic [31:0] PERIPH_ADDR;
    logic [31:0] PERIPH_DATA;
    logic        PERIPH_READY;
    logic        OVF;

    modport slave (
        input  IOBUS_WR, IOBUS_ADDR, IOBUS_OUT, PERIPH_READY,
        output BUF_FULL, BUF_EMPTY, PERIPH_VALID, PERIPH_ADDR, PERIPH_DATA, OVF
    );

    modport master (
        output IOBUS_WR, IOBUS_ADDR, IOBUS_OUT, PERIPH_READY,
        input  BUF_FULL, BUF_EMPTY, PERIPH_VALID, PERIPH_ADDR, PERIPH_DATA, OVF
    );

endinterface

// File: rtl/iobus_fifo.sv
// Circular store buffer: storage, wrap-around pointers and occupancy.
// next_head is the entry that will sit at the head after the current edge (write bypass included).
module iobus_fifo
    import otter_iobus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  iobus_entry_t           push_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count_next,
    output iobus_entry_t           next_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    iobus_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_ptr_next_s;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next;
        end
    end

    // Next occupancy and next head, bypassing a store that lands on the new head slot.
    always_comb begin
        count_next    = count_r;
        rd_ptr_next_s = rd_ptr_r;
        next_head     = mem_r[rd_ptr_r];
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next = count_r + CW'(1);
            2'b01:   count_next = count_r - CW'(1);
            default: count_next = count_r;
        endcase
        if (pop_ok_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
            next_head = push_entry;
        end else begin
            next_head = mem_r[rd_ptr_next_s];
        end
    end

endmodule

// File: rtl/iobus_write_buffer.sv
// MCU store write buffer: filters MMIO stores into a FIFO and drains them to the
// peripheral bus through a registered valid/ready port, flagging dropped stores.
module iobus_write_buffer
    import otter_iobus_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    iobus_write_buffer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_t  state_r;
    logic          valid_r;
    logic [31:0]   addr_r;
    logic [31:0]   data_r;
    logic          ovf_r;
    logic          wr_hit_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] count_next_s;
    iobus_entry_t  push_entry_s;
    iobus_entry_t  next_head_s;

    // A full buffer drops the store even if the head leaves in the same cycle.
    assign wr_hit_s     = bus.IOBUS_WR && in_mmio(bus.IOBUS_ADDR, MMIO_BASE);
    assign push_s       = wr_hit_s && !fifo_full_s;
    assign drop_s       = wr_hit_s && fifo_full_s;
    assign pop_s        = valid_r && bus.PERIPH_READY;
    assign push_entry_s = '{addr: bus.IOBUS_ADDR, data: bus.IOBUS_OUT};

    iobus_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_N),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (push_entry_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count_next (count_next_s),
        .next_head  (next_head_s)
    );

    // Drain FSM with registered head copy and sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            addr_r  <= 32'h0000_0000;
            data_r  <= 32'h0000_0000;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_next_s != CW'(0)) begin
                        state_r <= SEND;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                SEND: begin
                    if (pop_s && (count_next_s == CW'(0))) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= SEND;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
            if (count_next_s != CW'(0)) begin
                addr_r <= next_head_s.addr;
                data_r <= next_head_s.data;
            end
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign bus.BUF_FULL     = fifo_full_s;
    assign bus.BUF_EMPTY    = fifo_empty_s && (state_r == IDLE);
    assign bus.PERIPH_VALID = valid_r;
    assign bus.PERIPH_ADDR  = addr_r;
    assign bus.PERIPH_DATA  = data_r;
    assign bus.OVF          = ovf_r;

endmodule

// File: tb/tb_iobus_write_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_iobus_write_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1100_0000;

    logic CLK;
    logic RST_N;
    int   tests;
    int   fails;

    logic [63:0] q[$];
    logic        m_ovf;

    iobus_write_buffer_if bus();

    iobus_write_buffer #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance on the inputs sampled at the preceding rising edge, then compare.
    initial begin
        logic pop;
        logic hit;
        logic [63:0] head;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                pop = (q.size() > 0) && bus.PERIPH_READY;
                hit = bus.IOBUS_WR && (bus.IOBUS_ADDR >= BASE);
                if (pop) void'(q.pop_front());
                if (hit && (q.size() + (pop ? 1 : 0)) == DEPTH) m_ovf = 1'b1;
                else if (hit) q.push_back({bus.IOBUS_ADDR, bus.IOBUS_OUT});
            end
            chk("valid", {31'd0, bus.PERIPH_VALID}, {31'd0, q.size() != 0});
            chk("full",  {31'd0, bus.BUF_FULL},     {31'd0, q.size() == DEPTH});
            chk("empty", {31'd0, bus.BUF_EMPTY},    {31'd0, q.size() == 0});
            chk("ovf",   {31'd0, bus.OVF},          {31'd0, m_ovf});
            if (q.size() != 0) begin
                head = q[0];
                chk("addr", bus.PERIPH_ADDR, head[63:32]);
                chk("data", bus.PERIPH_DATA, head[31:0]);
            end
        end
    end

    // Apply one cycle of inputs; returns just after the next falling edge.
    task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic rdy);
        bus.IOBUS_WR     = wr;
        bus.IOBUS_ADDR   = addr;
        bus.IOBUS_OUT    = data;
        bus.PERIPH_READY = rdy;
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        bus.IOBUS_WR = 1'b0;
        RST_N = 1'b0;
        #1;
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        tests = 0;
        fails = 0;
        m_ovf = 1'b0;
        RST_N = 1'b0;
        bus.IOBUS_WR = 1'b0;
        bus.IOBUS_ADDR = 32'h0;
        bus.IOBUS_OUT = 32'h0;
        bus.PERIPH_READY = 1'b0;
        #12;
        chk("rst_valid", {31'd0, bus.PERIPH_VALID}, 32'd0);
        chk("rst_addr",  bus.PERIPH_ADDR, 32'h0);
        chk("rst_data",  bus.PERIPH_DATA, 32'h0);
        chk("rst_full",  {31'd0, bus.BUF_FULL}, 32'd0);
        chk("rst_empty", {31'd0, bus.BUF_EMPTY}, 32'd1);
        chk("rst_ovf",   {31'd0, bus.OVF}, 32'd0);
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1);

        // Single store, one-cycle latency, then drained.
        drive(1'b1, 32'h1100_0004, 32'hDEAD_BEEF, 1'b1);
        chk("single_valid", {31'd0, bus.PERIPH_VALID}, 32'd1);
        chk("single_addr", bus.PERIPH_ADDR, 32'h1100_0004);
        chk("single_data", bus.PERIPH_DATA, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("single_gone", {31'd0, bus.PERIPH_VALID}, 32'd0);
        chk("single_empty", {31'd0, bus.BUF_EMPTY}, 32'd1);

        // Out-of-window stores are ignored, including one below the base.
        drive(1'b1, 32'h0000_1000, 32'h1234_5678, 1'b1);
        chk("low_valid", {31'd0, bus.PERIPH_VALID}, 32'd0);
        chk("low_empty", {31'd0, bus.BUF_EMPTY}, 32'd1);
        chk("low_ovf", {31'd0, bus.OVF}, 32'd0);
        drive(1'b1, BASE - 32'd1, 32'h1, 1'b0);
        chk("base_m1", {31'd0, bus.PERIPH_VALID}, 32'd0);
        drive(1'b1, BASE, 32'hA5A5_0001, 1'b1);
        chk("base_addr", bus.PERIPH_ADDR, BASE);
        drive(1'b0, 32'h0, 32'h0, 1'b1);

        // Fill with READY low, overflow on the fifth, then drain back-to-back.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 32'(i), 1'b0);
            if (i == 4) chk("fill_full", {31'd0, bus.BUF_FULL}, 32'd1);
        end
        chk("fill_ovf", {31'd0, bus.OVF}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", bus.PERIPH_DATA, 32'(k));
            chk("drain_valid", {31'd0, bus.PERIPH_VALID}, 32'd1);
            drive(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("drain_done", {31'd0, bus.PERIPH_VALID}, 32'd0);

        // Asynchronous reset while holding three entries.
        for (int i = 0; i < 3; i++) drive(1'b1, BASE + 32'h100 + 32'(i), 32'h77 + 32'(i), 1'b0);
        chk("pre_rst_valid", {31'd0, bus.PERIPH_VALID}, 32'd1);
        bus.IOBUS_WR = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("async_valid", {31'd0, bus.PERIPH_VALID}, 32'd0);
        chk("async_empty", {31'd0, bus.BUF_EMPTY}, 32'd1);
        chk("async_ovf", {31'd0, bus.OVF}, 32'd0);
        chk("async_addr", bus.PERIPH_ADDR, 32'h0);
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("post_rst_valid", {31'd0, bus.PERIPH_VALID}, 32'd0);

        // Full buffer with simultaneous push and pop: push dropped, three remain.
        for (int i = 1; i <= 4; i++) drive(1'b1, BASE + 32'(i), 32'h10 + 32'(i), 1'b0);
        drive(1'b1, BASE + 32'h40, 32'h99, 1'b1);
        chk("fullpp_ovf", {31'd0, bus.OVF}, 32'd1);
        chk("fullpp_full", {31'd0, bus.BUF_FULL}, 32'd0);
        chk("fullpp_occ", 32'(q.size()), 32'd3);
        chk("fullpp_head", bus.PERIPH_DATA, 32'h12);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);

        // Occupancy 2 with steady push+pop across pointer wrap.
        drive(1'b1, BASE + 32'h200, 32'hB0, 1'b0);
        drive(1'b1, BASE + 32'h204, 32'hB1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, BASE + 32'h300 + 32'(4 * i), 32'd100 + 32'(i), 1'b1);
            chk("wrap_occ", 32'(q.size()), 32'd2);
        end
        chk("wrap_head", bus.PERIPH_DATA, 32'd108);
        for (int i = 0; i < 2; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("wrap_empty", {31'd0, bus.BUF_EMPTY}, 32'd1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       a = r & 32'h10FF_FFFF;
                1:       a = BASE - 32'd1;
                2:       a = BASE;
                default: a = BASE + (r & 32'h00FF_FFFF);
            endcase
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else drive(($urandom_range(0, 2) != 0), a, $urandom, ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
